// File: rtl/npu_conv2d_engine.sv
// Multi-channel valid 2-D convolution engine: streams features from external RAM,
// accumulates across all input channels into one output plane, emits on a valid/ready stream.
module npu_conv2d_engine #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int CH     = 2,
    localparam int N     = CH * K * K,
    localparam int WA_W  = (N > 1) ? $clog2(N) : 1,
    localparam int FA_W  = (CH * IMG_W * IMG_H > 1) ? $clog2(CH * IMG_W * IMG_H) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_relu_en,
    input  logic                     i_w_we,
    input  logic [WA_W-1:0]          i_w_addr,
    input  logic signed [DATA_W-1:0] i_w_data,
    output logic                     o_fm_rd,
    output logic [FA_W-1:0]          o_fm_addr,
    input  logic signed [DATA_W-1:0] i_fm_data,
    output logic                     o_out_valid,
    output logic signed [ACC_W-1:0]  o_out_data,
    input  logic                     i_out_ready,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int KC_W  = (K > 1) ? $clog2(K) : 1;
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int OX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OY_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MAC   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic logic signed [ACC_W-1:0] ext_prod(input logic signed [2*DATA_W-1:0] p);
        return ACC_W'(p);
    endfunction

    function automatic logic signed [ACC_W-1:0] relu_clip(input logic signed [ACC_W-1:0] v,
                                                          input logic en);
        return (en && v[ACC_W-1]) ? '0 : v;
    endfunction

    logic [2:0]                state;
    logic [WA_W-1:0]           cnt;
    logic [KC_W-1:0]           kx;
    logic [KC_W-1:0]           ky;
    logic [CH_W-1:0]           ch;
    logic [OX_W-1:0]           ox;
    logic [OY_W-1:0]           oy;
    logic                      relu_q;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DATA_W-1:0]  weights [N];

    logic                      vld_p1;
    logic [WA_W-1:0]           w_idx_p1;
    logic signed [2*DATA_W-1:0] prod_p1;

    // p1: RAM data for the read issued last cycle meets its weight
    assign prod_p1 = i_fm_data * weights[w_idx_p1];

    assign o_fm_rd     = (state == S_MAC);
    assign o_fm_addr   = FA_W'(ch) * FA_W'(IMG_W * IMG_H)
                       + (FA_W'(oy) + FA_W'(ky)) * FA_W'(IMG_W)
                       + FA_W'(ox) + FA_W'(kx);
    assign o_out_valid = (state == S_OUT);
    assign o_out_data  = relu_clip(acc, relu_q);
    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            kx       <= '0;
            ky       <= '0;
            ch       <= '0;
            ox       <= '0;
            oy       <= '0;
            relu_q   <= 1'b0;
            acc      <= '0;
            vld_p1   <= 1'b0;
            w_idx_p1 <= '0;
            for (int i = 0; i < N; i++) begin
                weights[i] <= '0;
            end
        end else begin
            vld_p1   <= (state == S_MAC);
            w_idx_p1 <= cnt;
            if (vld_p1) begin
                acc <= acc + ext_prod(prod_p1);
            end

            case (state)
                S_IDLE: begin
                    if (i_w_we && (int'(i_w_addr) < N)) begin
                        weights[i_w_addr] <= i_w_data;
                    end
                    if (i_start) begin
                        relu_q <= i_relu_en;
                        acc    <= '0;
                        cnt    <= '0;
                        kx     <= '0;
                        ky     <= '0;
                        ch     <= '0;
                        state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    // kx innermost, then ky, then channel
                    if (kx == KC_W'(K - 1)) begin
                        kx <= '0;
                        if (ky == KC_W'(K - 1)) begin
                            ky <= '0;
                            ch <= ch + 1'b1;
                        end else begin
                            ky <= ky + 1'b1;
                        end
                    end else begin
                        kx <= kx + 1'b1;
                    end
                    if (cnt == WA_W'(N - 1)) begin
                        cnt   <= '0;
                        ch    <= '0;
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (i_out_ready) begin
                        acc <= '0;
                        if (ox == OX_W'(OUT_W - 1)) begin
                            ox <= '0;
                            if (oy == OY_W'(OUT_H - 1)) begin
                                state <= S_DONE;
                            end else begin
                                oy    <= oy + 1'b1;
                                state <= S_MAC;
                            end
                        end else begin
                            ox    <= ox + 1'b1;
                            state <= S_MAC;
                        end
                    end
                end
                S_DONE: begin
                    ox    <= '0;
                    oy    <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npu_conv2d_engine.sv
// Directed bench for npu_conv2d_engine: RAM model, reference convolution feeding a
// scoreboard queue, monitor popping and comparing on every stream handshake.
module tb_npu_conv2d_engine;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int K      = 3;
    localparam int CH     = 2;
    localparam int N      = CH * K * K;
    localparam int OUT_W  = IMG_W - K + 1;
    localparam int OUT_H  = IMG_H - K + 1;
    localparam int FMN    = CH * IMG_W * IMG_H;
    localparam int WA_W   = $clog2(N);
    localparam int FA_W   = $clog2(FMN);
    localparam int JOB_CYC = OUT_W * OUT_H * (N + 2);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start = 1'b0;
    logic                     relu_en = 1'b0;
    logic                     w_we = 1'b0;
    logic [WA_W-1:0]          w_addr = '0;
    logic signed [DATA_W-1:0] w_data = '0;
    logic                     fm_rd;
    logic [FA_W-1:0]          fm_addr;
    logic signed [DATA_W-1:0] fm_data = '0;
    logic                     out_valid;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_ready = 1'b1;
    logic                     busy;
    logic                     done;

    logic signed [DATA_W-1:0] w_m  [N];
    logic signed [DATA_W-1:0] fm_m [FMN];
    logic signed [ACC_W-1:0]  sb [$];

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int done_count = 0;
    int rd_count = 0;
    logic stalling = 1'b0;
    logic signed [ACC_W-1:0] held = '0;

    npu_conv2d_engine #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .CH(CH)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_relu_en(relu_en),
        .i_w_we(w_we),
        .i_w_addr(w_addr),
        .i_w_data(w_data),
        .o_fm_rd(fm_rd),
        .o_fm_addr(fm_addr),
        .i_fm_data(fm_data),
        .o_out_valid(out_valid),
        .o_out_data(out_data),
        .i_out_ready(out_ready),
        .o_busy(busy),
        .o_done(done)
    );

    always #5 clk = ~clk;

    // synchronous feature RAM, one-cycle read latency
    always @(posedge clk) begin
        if (fm_rd) fm_data <= fm_m[fm_addr];
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [ACC_W-1:0] model(input int ox, input int oy, input logic relu);
        longint s = 0;
        for (int c = 0; c < CH; c++)
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++)
                    s += longint'(fm_m[c*IMG_W*IMG_H + (oy+ky)*IMG_W + ox + kx])
                       * longint'(w_m[c*K*K + ky*K + kx]);
        if (relu && s < 0) s = 0;
        return ACC_W'(s);
    endfunction

    // stream monitor: sampled mid-cycle, handshake completes at the next rising edge
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_count++;
            if (fm_rd) rd_count++;
            if (out_valid) begin
                chk("rd_during_out", fm_rd, 0);
                if (stalling) chk("stall_hold", out_data, held);
                if (out_ready) begin
                    chk("reads_per_px", rd_count, N);
                    rd_count = 0;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL unexpected_out: observed=%0d expected=none", out_data);
                    end else begin
                        chk("out_data", out_data, sb.pop_front());
                    end
                    hs_count++;
                    stalling = 1'b0;
                end else begin
                    held = out_data;
                    stalling = 1'b1;
                end
            end
        end
    end

    task automatic load_weights();
        for (int i = 0; i < N; i++) begin
            w_we = 1'b1;
            w_addr = WA_W'(i);
            w_data = w_m[i];
            @(posedge clk); #1;
        end
        w_we = 1'b0;
    endtask

    task automatic run_job(input logic relu, input int exp_cyc, input bit stall, input bit poke,
                           input int abort_at, input bit wr_start, input int wa, input int wd);
        int cyc = 0;
        int stall_left = 0;
        bit stall_done = 0;
        int done_before;
        if (wr_start) w_m[wa] = DATA_W'(wd);
        for (int oy = 0; oy < OUT_H; oy++)
            for (int ox = 0; ox < OUT_W; ox++)
                sb.push_back(model(ox, oy, relu));
        hs_count = 0;
        rd_count = 0;
        done_before = done_count;
        start = 1'b1;
        relu_en = relu;
        if (wr_start) begin
            w_we = 1'b1;
            w_addr = WA_W'(wa);
            w_data = DATA_W'(wd);
        end
        @(posedge clk); #1;
        start = 1'b0;
        w_we = 1'b0;
        while (cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (abort_at == cyc) begin
                chk("rd_before_rst", fm_rd, 1);
                rst = 1'b1;
                #1;
                chk("rst_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_fm_rd", fm_rd, 0);
                sb.delete();
                stalling = 1'b0;
                rd_count = 0;
                break;
            end
            if (done) break;
            if (cyc == 30) relu_en = ~relu_en;
            if (poke && cyc == 50) begin
                start = 1'b1;
                w_we = 1'b1;
                w_addr = '0;
                w_data = 8'sd7;
            end else if (poke && cyc == 51) begin
                start = 1'b0;
                w_we = 1'b0;
            end
            if (stall) begin
                if (stall_left > 0) begin
                    stall_left--;
                    if (stall_left == 0) out_ready = 1'b1;
                end else if (!stall_done && out_valid && hs_count == 2) begin
                    out_ready = 1'b0;
                    stall_left = 5;
                    stall_done = 1;
                end
            end
        end
        relu_en = 1'b0;
        out_ready = 1'b1;
        if (abort_at == 0) begin
            // done is visible for the cycle ending at edge t0 + exp_cyc + 1
            chk("done_time", cyc, exp_cyc);
            chk("sb_drained", sb.size(), 0);
            @(posedge clk); #1;
            chk("done_pulse", done, 0);
            chk("idle_busy", busy, 0);
            repeat (80) @(posedge clk);
            #1;
            chk("done_count", done_count - done_before, 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_fm_rd", fm_rd, 0);
        chk("rst_fm_addr", fm_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // all ones -> every output 18
        for (int i = 0; i < N; i++) w_m[i] = 8'sd1;
        for (int i = 0; i < FMN; i++) fm_m[i] = 8'sd1;
        load_weights();
        run_job(1'b0, JOB_CYC, 0, 0, 0, 0, 0, 0);

        // negative weights, then the same job with ReLU
        for (int i = 0; i < N; i++) w_m[i] = -8'sd1;
        load_weights();
        run_job(1'b0, JOB_CYC, 0, 0, 0, 0, 0, 0);
        run_job(1'b1, JOB_CYC, 0, 0, 0, 0, 0, 0);

        // ramp features, single ch0 centre tap written in the start cycle
        for (int c = 0; c < CH; c++)
            for (int y = 0; y < IMG_H; y++)
                for (int x = 0; x < IMG_W; x++)
                    fm_m[c*IMG_W*IMG_H + y*IMG_W + x] = DATA_W'(x + y);
        for (int i = 0; i < N; i++) w_m[i] = '0;
        load_weights();
        run_job(1'b0, JOB_CYC, 0, 0, 0, 1, 4, 1);

        // back-pressure on the third output
        run_job(1'b0, JOB_CYC + 5, 1, 0, 0, 0, 0, 0);

        // mixed weights, writes and starts while busy must be ignored
        for (int i = 0; i < N; i++) w_m[i] = DATA_W'(i - 9);
        load_weights();
        run_job(1'b0, JOB_CYC, 0, 1, 0, 0, 0, 0);
        run_job(1'b0, JOB_CYC, 0, 0, 0, 0, 0, 0);

        // asynchronous reset mid-job, then reload and rerun
        run_job(1'b0, JOB_CYC, 0, 0, 100, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        load_weights();
        run_job(1'b0, JOB_CYC, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
